tor_link_emulator: RTL
======================

# tor_link_emulator

One direction of the emulated ToR network between the two NIC instances. It replaces the fixed one-cycle loopback register between a NIC's network TX strobe and the peer NIC's network RX strobe. It adds a runtime-programmable propagation latency, an optional inter-packet gap to cap link bandwidth, a bounded in-flight buffer with tail-drop on overflow, and traffic counters. Two instances are used at top level, one per direction, clocked on the network clock (clk_div_2).

## Interface

Parameters:
- DEPTH, 64: in-flight packet capacity; power of two, at least 2.
- TS_WIDTH, 16: timestamp and configuration field width.
- CNT_WIDTH, 32: statistics counter width.

Ports:
- clk  in  1  network clock; all logic is in this single domain.
- reset  in  1  asynchronous, active-low reset; deassertion is synchronous to clk.
- in_data  in  $bits(NetworkPacketInternal)  packet from the sending NIC's network_tx_out.
- in_valid  in  1  single-cycle strobe per packet; there is no backpressure.
- out_data  out  $bits(NetworkPacketInternal)  packet to the receiving NIC's network_rx_in; registered.
- out_valid  out  1  single-cycle strobe per delivered packet; registered.
- cfg_latency  in  TS_WIDTH  target latency in cycles; sampled live.
- cfg_gap  in  TS_WIDTH  minimum cycles between out_valid strobes; 0 and 1 both mean back-to-back.
- stat_rx_cnt  out  CNT_WIDTH  packets accepted into the buffer.
- stat_tx_cnt  out  CNT_WIDTH  packets delivered.
- stat_drop_cnt  out  CNT_WIDTH  packets dropped because the buffer was full.
- stat_level  out  $clog2(DEPTH)+1  current buffer occupancy.

## Operation

- Free-running counter `now` (TS_WIDTH bits) increments every cycle and wraps modulo 2^TS_WIDTH.
- Push: on in_valid, if level < DEPTH, write {in_data, ts=now} at the tail and increment stat_rx_cnt. Otherwise drop the packet and increment stat_drop_cnt.
- A push while full is dropped even if a pop happens in the same cycle. This keeps drop behaviour deterministic.
- Age of the head entry = now − ts, computed modulo 2^TS_WIDTH.
- Pop is eligible when all three hold:
  - the buffer is non-empty;
  - age ≥ max(cfg_latency, 1);
  - gap_cnt = 0.
- Pop: register the head data into out_data, assert out_valid for one cycle, advance the head, increment stat_tx_cnt, and load gap_cnt with max(cfg_gap, 1) − 1.
- gap_cnt decrements each cycle while non-zero.
- A simultaneous push and pop when not full updates the level by net 0 and is legal.
- Order is strict FIFO. Packets are never reordered or duplicated.
- Changes to cfg_latency or cfg_gap take effect on the next cycle's eligibility check. Entries already buffered are re-evaluated against the new value.
- Wrap constraint: the system integrator guarantees cfg_latency + DEPTH·max(cfg_gap, 1) < 2^TS_WIDTH − 1. Outside this bound, delivery timing is undefined but FIFO order is still preserved.
- All counters wrap modulo 2^CNT_WIDTH and do not saturate.
- out_data holds its last value when out_valid = 0.

## Timing

- Latency: a packet strobed at edge T with an empty buffer and gap_cnt = 0 produces out_valid at edge T + max(cfg_latency, 1) + 1. The minimum is 2 cycles.
- Throughput: with cfg_gap ≤ 1, one packet per cycle. Otherwise one packet per cfg_gap cycles.
- Reset values, applied immediately on assertion:
  - out_valid = 0, out_data = 0;
  - all stat_* = 0, now = 0, gap_cnt = 0;
  - buffer empty.
- Asserting reset mid-operation discards all in-flight packets without emitting them.
- In the first cycle after reset deassertion, in_valid is accepted normally.
- stat_level reflects the state after the current edge's push and pop.
- The stat_* counters update on the same edge as the corresponding push, drop or pop.

## Structure

- Package tor_link_pkg:
  - typedef t_tor_entry, a struct of {NetworkPacketInternal pkt; logic [TS_WIDTH-1:0] ts;};
  - default parameter constants.
- NetworkPacketInternal stays in the existing NIC definitions package. tor_link_pkg imports it.
- Sub-module tor_link_fifo:
  - DEPTH-entry circular buffer of t_tor_entry;
  - head/tail pointers with an extra wrap bit;
  - full, empty and level outputs;
  - show-ahead read of the head entry.
- The top of tor_link_emulator holds `now`, the eligibility logic, gap_cnt, the output register and the counters.

## Test plan

- cfg_latency=10, cfg_gap=0, one packet at cycle 100 → out_valid at cycle 111 with identical data; rx=tx=1, drop=0.
- cfg_latency=0, cfg_gap=0, 8 back-to-back packets → 8 consecutive out_valid pulses starting 2 cycles after the first input, in order.
- cfg_latency=5, cfg_gap=4, 4 back-to-back packets → outputs at input+6, +10, +14, +18; stat_level peaks at 4.
- DEPTH=64, cfg_latency=1000, 70 back-to-back packets → 64 delivered in order, drop=6, stat_level=64 before release begins.
- cfg_latency=100, packet in at cycle 0, reset asserted at cycle 50 → out_valid never pulses; all stats=0. A fresh packet after deassertion arrives at input+101.
- Let `now` wrap: cfg_latency=20, packet strobed at now=2^16−5 → delivered 21 cycles later, data and order correct.

Source files
------------

// File: rtl/nic_pkg.sv
// NIC-side packet definitions shared by the NICs and the ToR link emulator.
package nic_pkg;

    typedef struct packed {
        logic [15:0] src_id;
        logic [15:0] dst_id;
        logic [31:0] payload;
    } NetworkPacketInternal;

endpackage

// File: rtl/tor_link_pkg.sv
// Shared types and default parameters for the ToR link emulator.
package tor_link_pkg;

    import nic_pkg::*;

    localparam int TOR_DEPTH     = 64;
    localparam int TOR_TS_WIDTH  = 16;
    localparam int TOR_CNT_WIDTH = 32;

    // One in-flight slot: the packet plus the `now` value it arrived at.
    typedef struct packed {
        NetworkPacketInternal      pkt;
        logic [TOR_TS_WIDTH-1:0]   ts;
    } t_tor_entry;

endpackage

// File: rtl/tor_link_fifo.sv
// Circular in-flight buffer with show-ahead head entry.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module tor_link_fifo
    import tor_link_pkg::*;
#(
    parameter int  DEPTH   = TOR_DEPTH,
    parameter type entry_t = t_tor_entry
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    entry_t      mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Advance the pointers; the caller only pushes when not full and pops when not empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage array; contents are don't-care while the slot is not occupied.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign level     = wr_ptr - rd_ptr;
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (level == (AW+1)'(DEPTH));
    assign head_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/tor_link_emulator.sv
// One direction of the emulated ToR link: programmable latency, optional
// inter-packet gap, bounded in-flight buffer with tail-drop, and counters.
//
// Handshake: in_valid and out_valid are single-cycle strobes with no ready.
// Every in_valid is either buffered or counted as a drop; every out_valid
// must be consumed by the receiver in that cycle.
module tor_link_emulator
    import nic_pkg::*;
    import tor_link_pkg::*;
#(
    parameter int DEPTH     = TOR_DEPTH,
    parameter int TS_WIDTH  = TOR_TS_WIDTH,
    parameter int CNT_WIDTH = TOR_CNT_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  NetworkPacketInternal       in_data,
    input  logic                       in_valid,
    output NetworkPacketInternal       out_data,
    output logic                       out_valid,
    input  logic [TS_WIDTH-1:0]        cfg_latency,
    input  logic [TS_WIDTH-1:0]        cfg_gap,
    output logic [CNT_WIDTH-1:0]       stat_rx_cnt,
    output logic [CNT_WIDTH-1:0]       stat_tx_cnt,
    output logic [CNT_WIDTH-1:0]       stat_drop_cnt,
    output logic [$clog2(DEPTH):0]     stat_level
);

    // Entry sized to this instance's timestamp width (t_tor_entry at defaults).
    typedef struct packed {
        NetworkPacketInternal  pkt;
        logic [TS_WIDTH-1:0]   ts;
    } entry_t;

    localparam logic [TS_WIDTH-1:0]  TS_ONE  = TS_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [TS_WIDTH-1:0] now;
    logic [TS_WIDTH-1:0] gap_cnt;
    logic [TS_WIDTH-1:0] age;
    logic [TS_WIDTH-1:0] lat_min;
    logic [TS_WIDTH-1:0] gap_load;
    entry_t              push_entry;
    entry_t              head_entry;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push_en;
    logic                drop_en;
    logic                pop_en;

    // A latency of 0 behaves like 1; a gap of 0 or 1 means back-to-back.
    assign lat_min  = (cfg_latency == '0) ? TS_ONE : cfg_latency;
    assign gap_load = (cfg_gap == '0) ? '0 : (cfg_gap - TS_ONE);

    // Age is modular so it stays correct across a wrap of `now`.
    assign age = now - head_entry.ts;

    // Drop decision uses the pre-edge full flag, so a same-cycle pop never rescues a push.
    assign push_en = in_valid && !fifo_full;
    assign drop_en = in_valid && fifo_full;
    assign pop_en  = !fifo_empty && (age >= lat_min) && (gap_cnt == '0);

    assign push_entry.pkt = in_data;
    assign push_entry.ts  = now;

    tor_link_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_en),
        .push_data (push_entry),
        .pop       (pop_en),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (stat_level)
    );

    // Free-running timestamp source; wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) now <= '0;
        else        now <= now + TS_ONE;
    end

    // Inter-packet gap: reload on delivery, then count down to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)              gap_cnt <= '0;
        else if (pop_en)         gap_cnt <= gap_load;
        else if (gap_cnt != '0)  gap_cnt <= gap_cnt - TS_ONE;
    end

    // Output register; data holds its last value between strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= pop_en;
            if (pop_en) out_data <= head_entry.pkt;
        end
    end

    // Traffic counters; wrap without saturation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_rx_cnt   <= '0;
            stat_tx_cnt   <= '0;
            stat_drop_cnt <= '0;
        end else begin
            if (push_en) stat_rx_cnt   <= stat_rx_cnt + CNT_ONE;
            if (pop_en)  stat_tx_cnt   <= stat_tx_cnt + CNT_ONE;
            if (drop_en) stat_drop_cnt <= stat_drop_cnt + CNT_ONE;
        end
    end

endmodule
